cdb_requester: RTL and testbench

- Per-functional-unit result buffer; the requesting side of the CDB arbitration interface.
- Queues completed FU results and raises cdb_req to the arbiter.
- Drives the head result onto its CDB slot in the cycle its fu_sel bit is asserted.
- One instance per FU: ld/st owns fu_sel[2], ALU1 owns fu_sel[1], ALU0 owns fu_sel[0].

---
 rtl/cdb_requester_pkg.sv | 13 +
 rtl/cdb_requester_if.sv | 26 ++
 rtl/cdb_result_fifo.sv | 45 ++++
 rtl/cdb_requester.sv | 48 ++++
 tb/tb_cdb_requester.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/cdb_requester_pkg.sv
// cdb_requester_pkg: CDB result struct and functional-unit indices shared by the requesters and the arbiter.
package cdb_requester_pkg;
    localparam int CDB_TAG_W  = 4;
    localparam int CDB_DATA_W = 32;
    localparam int FU_LDST = 2;
    localparam int FU_ALU1 = 1;
    localparam int FU_ALU0 = 0;
    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_struct_t;
endpackage

// File: rtl/cdb_requester_if.sv
// cdb_requester_if: FU result input, arbiter request/grant and CDB drive of one requester.
interface cdb_requester_if #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    import cdb_requester_pkg::*;
    logic                         res_valid;
    logic [TAG_W-1:0]             res_tag;
    logic [DATA_W-1:0]            res_data;
    logic                         res_ready;
    logic                         flush;
    logic                         cdb_req;
    logic [2:0]                   fu_sel;
    cdb_struct_t                  cdb_out;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         ovf_err;
    modport master (
        input  res_valid, res_tag, res_data, flush, fu_sel,
        output res_ready, cdb_req, cdb_out, count, ovf_err
    );
    modport slave (
        output res_valid, res_tag, res_data, flush, fu_sel,
        input  res_ready, cdb_req, cdb_out, count, ovf_err
    );
endinterface

// File: rtl/cdb_result_fifo.sv
// cdb_result_fifo: result storage with wrapping pointers; full/empty come from the occupancy count.
module cdb_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
endmodule

// File: rtl/cdb_requester.sv
// cdb_requester: queues one FU's results, requests the CDB and broadcasts the head in its grant cycle.
module cdb_requester
    import cdb_requester_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DATA_W = CDB_DATA_W,
    parameter int FU_IDX = FU_ALU0
) (
    input logic               clk,
    input logic               rst,
    cdb_requester_if.master   cdb
);
    localparam int CW = $clog2(DEPTH+1);
    logic                    w_grant;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [CW-1:0]           w_count;
    logic [TAG_W+DATA_W-1:0] w_head;
    logic                    r_ovf_err;
    assign w_grant = cdb.fu_sel[FU_IDX];
    assign w_push  = cdb.res_valid && !w_full && !cdb.flush;
    assign w_pop   = w_grant && !w_empty && !cdb.flush;
    cdb_result_fifo #(.DEPTH(DEPTH), .W(TAG_W+DATA_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (cdb.flush),
        .i_wdata ({cdb.res_tag, cdb.res_data}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ovf_err <= 1'b0;
        else if (cdb.res_valid && w_full && !cdb.flush) r_ovf_err <= 1'b1;
    end
    // Request drops in the cycle the last entry is granted: the arbiter's grant lags by one cycle.
    assign cdb.cdb_req   = !cdb.flush && (w_count > CW'(w_grant));
    assign cdb.cdb_out   = w_pop ? {1'b1, w_head} : '0;
    assign cdb.res_ready = !w_full;
    assign cdb.count     = w_count;
    assign cdb.ovf_err   = r_ovf_err;
endmodule

// File: tb/tb_cdb_requester.sv
// tb_cdb_requester: directed and random stimulus against a queue-based model of the requester.
module tb_cdb_requester;
    import cdb_requester_pkg::*;
    localparam int DEPTH = 4;
    localparam int FU = 1;
    localparam logic [2:0] SEL = 3'(1 << FU);
    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
    } ent_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    cdb_requester_if #(.DEPTH(DEPTH), .TAG_W(4), .DATA_W(32)) bus ();
    cdb_requester #(.DEPTH(DEPTH), .TAG_W(4), .DATA_W(32), .FU_IDX(FU)) dut (
        .clk (clk),
        .rst (rst),
        .cdb (bus)
    );
    ent_t q[$];
    logic m_ovf = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [3:0] got[$];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic model_step();
        int n;
        n = q.size();
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
        end else if (bus.flush) begin
            q.delete();
        end else begin
            if (bus.res_valid && n == DEPTH) m_ovf = 1'b1;
            if (bus.fu_sel[FU] && n > 0) void'(q.pop_front());
            if (bus.res_valid && n < DEPTH) q.push_back('{bus.res_tag, bus.res_data});
        end
    endtask
    task automatic cyc(input logic v, input logic [3:0] t, input logic [31:0] d, input logic [2:0] s, input logic f);
        @(posedge clk);
        model_step();
        #2;
        bus.res_valid = v;
        bus.res_tag = t;
        bus.res_data = d;
        bus.fu_sel = s;
        bus.flush = f;
    endtask
    task automatic settle();
        @(negedge clk);
        #1;
    endtask
    task automatic do_reset();
        @(posedge clk);
        model_step();
        #2;
        rst = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        bus.res_valid = 1'b0;
        bus.fu_sel = '0;
        bus.flush = 1'b0;
        @(posedge clk);
        model_step();
        #2;
        rst = 1'b0;
    endtask
    always @(negedge clk) begin
        int n;
        int g;
        logic v;
        logic [63:0] exp_out;
        n = q.size();
        g = int'(bus.fu_sel[FU]);
        v = g == 1 && n > 0 && !bus.flush;
        exp_out = v ? {27'd0, 1'b1, q[0].tag, q[0].data} : 64'd0;
        chk("res_ready", 64'(bus.res_ready), 64'(n < DEPTH));
        chk("count", 64'(bus.count), 64'(n));
        chk("ovf_err", 64'(bus.ovf_err), 64'(m_ovf));
        chk("cdb_req", 64'(bus.cdb_req), 64'(!bus.flush && (n - g) > 0));
        chk("cdb_out", 64'(bus.cdb_out), exp_out);
    end
    initial begin
        bus.res_valid = 1'b0;
        bus.res_tag = '0;
        bus.res_data = '0;
        bus.fu_sel = '0;
        bus.flush = 1'b0;
        do_reset();
        settle();
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_ready", 64'(bus.res_ready), 64'd1);
        // single result
        cyc(1'b1, 4'd5, 32'hDEADBEEF, 3'd0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 3'd0, 1'b0);
        settle();
        chk("single_req_n1", 64'(bus.cdb_req), 64'd1);
        cyc(1'b0, 4'd0, 32'd0, SEL, 1'b0);
        settle();
        chk("single_bcast", 64'(bus.cdb_out), {27'd0, 1'b1, 4'd5, 32'hDEADBEEF});
        chk("single_req_n2", 64'(bus.cdb_req), 64'd0);
        cyc(1'b0, 4'd0, 32'd0, 3'd0, 1'b0);
        settle();
        chk("single_count_n3", 64'(bus.count), 64'd0);
        // fill and overflow
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'(10 + i), 32'(i * 7), 3'd0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 3'd0, 1'b0);
        settle();
        chk("fill_ready", 64'(bus.res_ready), 64'd0);
        chk("fill_count", 64'(bus.count), 64'd4);
        cyc(1'b1, 4'd15, 32'hFFFF, 3'd0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 3'd0, 1'b0);
        settle();
        chk("ovf_set", 64'(bus.ovf_err), 64'd1);
        chk("ovf_count", 64'(bus.count), 64'd4);
        got.delete();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 4'd0, 32'd0, SEL, 1'b0);
            settle();
            if (bus.cdb_out.valid) got.push_back(bus.cdb_out.tag);
        end
        chk("ovf_drain_n", 64'(got.size()), 64'd4);
        for (int i = 0; i < got.size(); i++) chk("ovf_drain_tag", 64'(got[i]), 64'(10 + i));
        // wrap and order
        do_reset();
        got.delete();
        for (int i = 1; i <= 10; i++) begin
            cyc(i <= 6, 4'(i), 32'(i * 17), SEL, 1'b0);
            settle();
            if (bus.cdb_out.valid) got.push_back(bus.cdb_out.tag);
        end
        chk("wrap_n", 64'(got.size()), 64'd6);
        for (int i = 0; i < got.size(); i++) chk("wrap_order", 64'(got[i]), 64'(i + 1));
        // push and pop at full
        do_reset();
        for (int i = 1; i <= 4; i++) cyc(1'b1, 4'(i), 32'(i), 3'd0, 1'b0);
        cyc(1'b1, 4'd9, 32'd9, SEL, 1'b0);
        settle();
        chk("full_pp_ready", 64'(bus.res_ready), 64'd0);
        chk("full_pp_bcast", 64'(bus.cdb_out), {27'd0, 1'b1, 4'd1, 32'd1});
        cyc(1'b0, 4'd0, 32'd0, 3'd0, 1'b0);
        settle();
        chk("full_pp_count", 64'(bus.count), 64'd3);
        // flush with pending grant
        do_reset();
        cyc(1'b1, 4'd3, 32'd3, 3'd0, 1'b0);
        cyc(1'b1, 4'd4, 32'd4, 3'd0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 3'd0, 1'b1);
        settle();
        chk("flush_valid_n", 64'(bus.cdb_out.valid), 64'd0);
        chk("flush_req_n", 64'(bus.cdb_req), 64'd0);
        cyc(1'b0, 4'd0, 32'd0, SEL, 1'b0);
        settle();
        chk("flush_valid_n1", 64'(bus.cdb_out.valid), 64'd0);
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_ovf", 64'(bus.ovf_err), 64'd0);
        // reset mid-operation
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i), 32'(i), 3'd0, 1'b0);
        @(posedge clk);
        model_step();
        #2;
        rst = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        bus.res_valid = 1'b0;
        settle();
        chk("rst_mid_count", 64'(bus.count), 64'd0);
        chk("rst_mid_req", 64'(bus.cdb_req), 64'd0);
        chk("rst_mid_valid", 64'(bus.cdb_out.valid), 64'd0);
        chk("rst_mid_ready", 64'(bus.res_ready), 64'd1);
        @(posedge clk);
        model_step();
        #2;
        rst = 1'b0;
        // random traffic
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 9) < 6, 4'($urandom), 32'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 99) < 3);
        cyc(1'b0, 4'd0, 32'd0, 3'd0, 1'b0);
        settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
